// File: rtl/xoodoo_rdi_ctrl.sv
// Sequencer for the masked Xoodoo round: per-round rdi0/rdi1 strobes, fresh LFSR randomness,
// round constants and first-round select. 3 cycles per round; start/seed_load are only honoured in IDLE.
module xoodoo_rdi_ctrl #(
    parameter int NROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [383:0] seed_in,
    input  logic         seed_load,
    input  logic         start,
    output logic [383:0] rdi,
    output logic         rdi0_en,
    output logic         rdi1_en,
    output logic [31:0]  rconst,
    output logic         first_round,
    output logic         busy,
    output logic         perm_done
);

    typedef enum logic [2:0] {IDLE, R0, R1, R2, DONE} state_t;

    localparam logic [3:0] LAST_RND = 4'(NROUNDS - 1);
    localparam logic [3:0] RC_BASE  = 4'(12 - NROUNDS);

    state_t       state, state_nxt;
    logic [3:0]   round_cnt, round_cnt_nxt;
    logic         seeded;
    logic [383:0] lanes, lanes_step, seed_fixed;

    function automatic logic [31:0] rc_lookup(input logic [3:0] idx);
        case (idx)
            4'd0:    rc_lookup = 32'h58;
            4'd1:    rc_lookup = 32'h38;
            4'd2:    rc_lookup = 32'h3C0;
            4'd3:    rc_lookup = 32'hD0;
            4'd4:    rc_lookup = 32'h120;
            4'd5:    rc_lookup = 32'h14;
            4'd6:    rc_lookup = 32'h60;
            4'd7:    rc_lookup = 32'h2C;
            4'd8:    rc_lookup = 32'h380;
            4'd9:    rc_lookup = 32'hF0;
            4'd10:   rc_lookup = 32'h1A0;
            4'd11:   rc_lookup = 32'h12;
            default: rc_lookup = 32'h0;
        endcase
    endfunction

    // A zero lane would lock the LFSR, so it is replaced by 1 on load.
    always_comb begin
        lanes_step = '0;
        seed_fixed = '0;
        for (int i = 0; i < 12; i++) begin
            lanes_step[32*i +: 32] = lanes[32*i] ? ((lanes[32*i +: 32] >> 1) ^ 32'h8020_0003)
                                                 : (lanes[32*i +: 32] >> 1);
            seed_fixed[32*i +: 32] = (seed_in[32*i +: 32] == 32'h0) ? 32'h1 : seed_in[32*i +: 32];
        end
    end

    always_comb begin
        state_nxt     = state;
        round_cnt_nxt = round_cnt;
        rdi           = '0;
        rdi0_en       = 1'b0;
        rdi1_en       = 1'b0;
        rconst        = 32'h0;
        first_round   = 1'b0;
        busy          = 1'b0;
        perm_done     = 1'b0;
        case (state)
            IDLE: begin
                if (start && seeded && !seed_load)
                    state_nxt = R0;
            end
            R0: begin
                rdi0_en     = 1'b1;
                rdi         = lanes;
                rconst      = rc_lookup(RC_BASE + round_cnt);
                first_round = (round_cnt == 4'd0);
                busy        = 1'b1;
                state_nxt   = R1;
            end
            R1: begin
                // Lanes already stepped once at the end of R0.
                rdi1_en     = 1'b1;
                rdi         = lanes;
                rconst      = rc_lookup(RC_BASE + round_cnt);
                first_round = (round_cnt == 4'd0);
                busy        = 1'b1;
                state_nxt   = R2;
            end
            R2: begin
                rconst      = rc_lookup(RC_BASE + round_cnt);
                first_round = (round_cnt == 4'd0);
                busy        = 1'b1;
                if (round_cnt < LAST_RND) begin
                    round_cnt_nxt = round_cnt + 4'd1;
                    state_nxt     = R0;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy          = 1'b1;
                perm_done     = 1'b1;
                round_cnt_nxt = 4'd0;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_cnt <= 4'd0;
            seeded    <= 1'b0;
            lanes     <= {12{32'h0000_0001}};
        end else begin
            state     <= state_nxt;
            round_cnt <= round_cnt_nxt;
            if (state == IDLE && seed_load) begin
                lanes  <= seed_fixed;
                seeded <= 1'b1;
            end else if (rdi0_en || rdi1_en) begin
                lanes <= lanes_step;
            end
        end
    end

endmodule
